pwm_capture: RTL and testbench

- Measures an incoming PWM signal, such as a servo command from an RC receiver or a loop-back of the servo drive output.
- Reports high time and period, both in clock cycles, with a one-cycle valid strobe.
- Inverse of the servo PWM generator: converts a pulse train back into the pulseTime and period numbers.
- Sits beside the servo drive blocks in the Computer_System and feeds a register interface or the control logic.

---
 rtl/servo_pkg.sv | 16 +
 rtl/pwm_capture_sync.sv | 77 +++++++
 rtl/pwm_capture.sv | 86 ++++++++
 tb/tb_pwm_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo definitions: capture FSM states, servo frame length and default sizing.
// Imported by pwm_capture and the servo drive blocks.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH,
    LOW
  } cap_state_t;

  localparam int SERVO_PERIOD_CYCLES = 2000000;
  localparam int DEFAULT_TIMEOUT     = 2 * SERVO_PERIOD_CYCLES;
  localparam int DEFAULT_CNT_W       = 32;

endpackage

// File: rtl/pwm_capture_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch filter
// (enabled by PWM_CAPTURE_FILTER_EN) and rise/fall detection on the conditioned level.
module pwm_input_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock_clk,
  input  logic reset_low,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ready
);

`ifdef PWM_CAPTURE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  // The flops reset to 0, so level reads a fake low until real input has flushed through.
  localparam int PRIME_CYC = 2 + (FILTER_EN ? FILTER_LEN : 0);
  localparam int PRIME_W   = $clog2(PRIME_CYC + 1);

  logic               s1_p0;
  logic               s2_p1;
  logic               prev_p2;
  logic [PRIME_W-1:0] prime_cnt;

  // Stage p0/p1: synchronizer; p2: previous conditioned level
  always_ff @(posedge clock_clk) begin
    if (!reset_low) begin
      s1_p0     <= 1'b0;
      s2_p1     <= 1'b0;
      prev_p2   <= 1'b0;
      prime_cnt <= '0;
    end else begin
      s1_p0   <= pwm_in;
      s2_p1   <= s1_p0;
      prev_p2 <= level;
      if (!ready) prime_cnt <= prime_cnt + 1'b1;
    end
  end

  assign ready = (prime_cnt == PRIME_W'(PRIME_CYC));

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int RUN_W = $clog2(FILTER_LEN) + 1;

  logic             filt_p2;
  logic [RUN_W-1:0] run_cnt_p2;

  // Stage p2: level flips only after FILTER_LEN consecutive samples of the new value
  always_ff @(posedge clock_clk) begin
    if (!reset_low) begin
      filt_p2    <= 1'b0;
      run_cnt_p2 <= '0;
    end else if (s2_p1 != filt_p2) begin
      if (run_cnt_p2 == RUN_W'(FILTER_LEN - 1)) begin
        filt_p2    <= s2_p1;
        run_cnt_p2 <= '0;
      end else begin
        run_cnt_p2 <= run_cnt_p2 + 1'b1;
      end
    end else begin
      run_cnt_p2 <= '0;
    end
  end

  assign level = filt_p2;
`else
  assign level = s2_p1;
`endif

  assign rise = level & ~prev_p2;
  assign fall = ~level & prev_p2;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period in clock cycles.
// Optional input glitch filter selected with `define PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import servo_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int FILTER_LEN = 4
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_time,
  output logic [CNT_W-1:0] period_time,
  output logic             sample_valid,
  output logic             signal_lost
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             level;
  logic             rise;
  logic             fall;
  logic             ready;
  cap_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;

  pwm_input_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .clock_clk(clock_clk),
    .reset_low(reset_low),
    .pwm_in   (pwm_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .ready    (ready)
  );

  // Stage p3: counter, FSM and output registers
  always_ff @(posedge clock_clk) begin
    if (!reset_low) begin
      state        <= IDLE;
      cnt          <= '0;
      high_lat     <= '0;
      pulse_time   <= '0;
      period_time  <= '0;
      sample_valid <= 1'b0;
      signal_lost  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (rise)                   cnt <= CNT_W'(1);
      else if (cnt != TIMEOUT_C)  cnt <= cnt + 1'b1;

      // An edge seen in the same cycle as the timeout takes priority.
      case (state)
        IDLE:  if (ready && !level) state <= ARMED;
        ARMED: if (rise) state <= HIGH;
        HIGH: begin
          if (fall) begin
            high_lat <= cnt;
            state    <= LOW;
          end else if (cnt == TIMEOUT_C) begin
            signal_lost <= 1'b1;
            state       <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            pulse_time   <= high_lat;
            period_time  <= cnt;
            sample_valid <= 1'b1;
            signal_lost  <= 1'b0;
            state        <= HIGH;
          end else if (cnt == TIMEOUT_C) begin
            signal_lost <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture with TIMEOUT=100 and a pulse-train reference model.
module tb_pwm_capture;

  localparam int CNT_W = 32;
  localparam int TMO   = 100;
  localparam int FLEN  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT   = 3 + FLEN;
  localparam int MIN_W = FLEN;
`else
  localparam int LAT   = 3;
  localparam int MIN_W = 1;
`endif

  logic             clock_clk = 1'b0;
  logic             reset_low = 1'b0;
  logic             pwm_in    = 1'b0;
  logic [CNT_W-1:0] pulse_time;
  logic [CNT_W-1:0] period_time;
  logic             sample_valid;
  logic             signal_lost;

  typedef struct {
    int pulse;
    int period;
    bit lost;
    int cyc;
  } samp_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    prev_sv = 1'b0;
  samp_t mon_q[$];
  int    hq[$];
  int    lq[$];
  int    rise_cyc[$];

  pwm_capture #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TMO),
    .FILTER_LEN(FLEN)
  ) dut (
    .clock_clk   (clock_clk),
    .reset_low   (reset_low),
    .pwm_in      (pwm_in),
    .pulse_time  (pulse_time),
    .period_time (period_time),
    .sample_valid(sample_valid),
    .signal_lost (signal_lost)
  );

  always #5 clock_clk = ~clock_clk;
  always @(posedge clock_clk) cyc <= cyc + 1;

  // Collect every strobe; strobes must never appear in adjacent cycles.
  always @(negedge clock_clk) begin
    if (sample_valid) begin
      mon_q.push_back('{int'(pulse_time), int'(period_time), signal_lost, cyc});
      n_cmp++;
      if (prev_sv) begin
        n_fail++;
        $display("FAIL isolated_strobe: sample_valid high two cycles running at cyc %0d, required single-cycle", cyc);
      end
    end
    prev_sv = sample_valid;
  end

  task automatic set_level(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clock_clk);
    #1;
  endtask

  task automatic do_reset(input bit v);
    pwm_in    = v;
    reset_low = 1'b0;
    repeat (3) @(posedge clock_clk);
    #1;
    reset_low = 1'b1;
    mon_q.delete();
  endtask

  // Drive hq/lq as rise-started periods, then one closing rise.
  task automatic play();
    rise_cyc.delete();
    foreach (hq[k]) begin
      rise_cyc.push_back(cyc);
      set_level(1'b1, hq[k]);
      set_level(1'b0, lq[k]);
    end
    rise_cyc.push_back(cyc);
    pwm_in = 1'b1;
    repeat (LAT + 3) @(posedge clock_clk);
    #1;
  endtask

  task automatic wait_cyc(input int tgt);
    while (cyc < tgt) begin
      @(posedge clock_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    pwm_in    = 1'b1;
    reset_low = 1'b0;
    repeat (2) @(posedge clock_clk);
    #1;
    n_cmp += 4;
    if (pulse_time !== '0)   begin n_fail++; $display("FAIL reset_pulse: %0d, required 0", pulse_time); end
    if (period_time !== '0)  begin n_fail++; $display("FAIL reset_period: %0d, required 0", period_time); end
    if (sample_valid !== 0)  begin n_fail++; $display("FAIL reset_valid: %b, required 0", sample_valid); end
    if (signal_lost !== 0)   begin n_fail++; $display("FAIL reset_lost: %b, required 0", signal_lost); end
    reset_low = 1'b1;
    set_level(1'b1, 8);
    n_cmp += 2;
    if (mon_q.size() != 0)  begin n_fail++; $display("FAIL reset_idle_valid: %0d samples, required 0", mon_q.size()); end
    if (signal_lost !== 0)  begin n_fail++; $display("FAIL reset_idle_lost: %b, required 0", signal_lost); end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    set_level(1'b0, 10);
    hq = '{30, 30, 30, 30};
    lq = '{70, 70, 70, 70};
    play();
    n_cmp++;
    if (mon_q.size() != hq.size()) begin n_fail++; $display("FAIL basic_count: %0d samples, required %0d", mon_q.size(), hq.size()); end
    for (int k = 0; k < mon_q.size() && k < hq.size(); k++) begin
      n_cmp++;
      if (mon_q[k].pulse != hq[k] || mon_q[k].period != hq[k] + lq[k] || mon_q[k].lost || mon_q[k].cyc != rise_cyc[k+1] + LAT) begin
        n_fail++;
        $display("FAIL basic_sample%0d: %0d/%0d lost=%0b cyc=%0d, required %0d/%0d lost=0 cyc=%0d", k, mon_q[k].pulse,
                 mon_q[k].period, mon_q[k].lost, mon_q[k].cyc, hq[k], hq[k] + lq[k], rise_cyc[k+1] + LAT);
      end
    end
  endtask

  task automatic test_high_at_reset();
    do_reset(1'b1);
    set_level(1'b1, 15);
    set_level(1'b0, 50);
    n_cmp++;
    if (mon_q.size() != 0) begin n_fail++; $display("FAIL partial_valid: %0d samples, required 0", mon_q.size()); end
    hq = '{20, 20, 20};
    lq = '{50, 50, 50};
    play();
    n_cmp++;
    if (mon_q.size() != hq.size()) begin n_fail++; $display("FAIL partial_count: %0d samples, required %0d", mon_q.size(), hq.size()); end
    for (int k = 0; k < mon_q.size() && k < hq.size(); k++) begin
      n_cmp++;
      if (mon_q[k].pulse != 20 || mon_q[k].period != 70 || mon_q[k].cyc != rise_cyc[k+1] + LAT) begin
        n_fail++;
        $display("FAIL partial_sample%0d: %0d/%0d cyc=%0d, required 20/70 cyc=%0d", k, mon_q[k].pulse, mon_q[k].period,
                 mon_q[k].cyc, rise_cyc[k+1] + LAT);
      end
    end
  endtask

  task automatic test_timeout_low();
    int rc;
    do_reset(1'b0);
    set_level(1'b0, 10);
    hq = '{30, 30};
    lq = '{70, 70};
    play();
    n_cmp++;
    if (mon_q.size() != 2) begin n_fail++; $display("FAIL tmo_pre_count: %0d samples, required 2", mon_q.size()); end
    rc = rise_cyc[2];
    set_level(1'b1, 30 - (LAT + 3));
    pwm_in = 1'b0;
    wait_cyc(rc + LAT + TMO - 1);
    n_cmp++;
    if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL tmo_early: lost=%b one cycle before timeout, required 0", signal_lost); end
    wait_cyc(rc + LAT + TMO);
    n_cmp += 2;
    if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL tmo_lost: lost=%b at timeout, required 1", signal_lost); end
    if (pulse_time !== 30 || period_time !== 100) begin
      n_fail++; $display("FAIL tmo_hold: %0d/%0d, required 30/100", pulse_time, period_time);
    end
    set_level(1'b0, 20);
    n_cmp += 2;
    if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: lost=%b, required 1", signal_lost); end
    if (mon_q.size() != 2)    begin n_fail++; $display("FAIL tmo_no_sample: %0d samples, required 2", mon_q.size()); end
    mon_q.delete();
    hq = '{30};
    lq = '{70};
    play();
    n_cmp += 2;
    if (mon_q.size() != 1 || mon_q[0].pulse != 30 || mon_q[0].period != 100 || mon_q[0].lost) begin
      n_fail++; $display("FAIL tmo_resume: %0d samples, first lost=%0b, required one 30/100 sample with lost=0", mon_q.size(),
                         (mon_q.size() > 0) ? mon_q[0].lost : 1'b1);
    end
    if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared: lost=%b, required 0", signal_lost); end
  endtask

  task automatic test_exact_period();
    int rc;
    do_reset(1'b0);
    set_level(1'b0, 10);
    hq = '{60, 100 - 5, 5};
    lq = '{40, 5, 100 - 5};
    play();
    n_cmp++;
    if (mon_q.size() != hq.size()) begin n_fail++; $display("FAIL exact_count: %0d samples, required %0d", mon_q.size(), hq.size()); end
    for (int k = 0; k < mon_q.size() && k < hq.size(); k++) begin
      n_cmp++;
      if (mon_q[k].pulse != hq[k] || mon_q[k].period != TMO || mon_q[k].lost) begin
        n_fail++;
        $display("FAIL exact_sample%0d: %0d/%0d lost=%0b, required %0d/%0d lost=0", k, mon_q[k].pulse, mon_q[k].period,
                 mon_q[k].lost, hq[k], TMO);
      end
    end
    // Input now stays high: a constant high must also time out.
    rc = rise_cyc[hq.size()];
    wait_cyc(rc + LAT + TMO - 1);
    n_cmp++;
    if (signal_lost !== 1'b0) begin n_fail++; $display("FAIL high_tmo_early: lost=%b, required 0", signal_lost); end
    wait_cyc(rc + LAT + TMO);
    n_cmp++;
    if (signal_lost !== 1'b1) begin n_fail++; $display("FAIL high_tmo: lost=%b, required 1", signal_lost); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    set_level(1'b0, 10);
    hq = '{30, 30};
    lq = '{70, 70};
    play();
    reset_low = 1'b0;
    set_level(1'b1, 1);
    n_cmp += 2;
    if (pulse_time !== '0 || period_time !== '0) begin
      n_fail++; $display("FAIL mid_reset_vals: %0d/%0d, required 0/0", pulse_time, period_time);
    end
    if (sample_valid !== 1'b0 || signal_lost !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_flags: valid=%b lost=%b, required 0/0", sample_valid, signal_lost);
    end
    reset_low = 1'b1;
    mon_q.delete();
    set_level(1'b1, 30 - (LAT + 3) - 1);
    set_level(1'b0, 70);
    hq = '{30, 30};
    lq = '{70, 70};
    play();
    n_cmp++;
    if (mon_q.size() != 2) begin n_fail++; $display("FAIL mid_reset_count: %0d samples, required 2", mon_q.size()); end
    for (int k = 0; k < mon_q.size() && k < 2; k++) begin
      n_cmp++;
      if (mon_q[k].pulse != 30 || mon_q[k].period != 100 || mon_q[k].cyc != rise_cyc[k+1] + LAT) begin
        n_fail++;
        $display("FAIL mid_reset_sample%0d: %0d/%0d cyc=%0d, required 30/100 cyc=%0d", k, mon_q[k].pulse, mon_q[k].period,
                 mon_q[k].cyc, rise_cyc[k+1] + LAT);
      end
    end
  endtask

  task automatic test_min_period();
    do_reset(1'b0);
    set_level(1'b0, 10);
    hq.delete();
    lq.delete();
    repeat (6) begin
      hq.push_back(MIN_W);
      lq.push_back(MIN_W);
    end
    play();
    n_cmp++;
    if (mon_q.size() != hq.size()) begin n_fail++; $display("FAIL minper_count: %0d samples, required %0d", mon_q.size(), hq.size()); end
    for (int k = 0; k < mon_q.size() && k < hq.size(); k++) begin
      n_cmp++;
      if (mon_q[k].pulse != MIN_W || mon_q[k].period != 2 * MIN_W || mon_q[k].cyc != rise_cyc[k+1] + LAT) begin
        n_fail++;
        $display("FAIL minper_sample%0d: %0d/%0d cyc=%0d, required %0d/%0d cyc=%0d", k, mon_q[k].pulse, mon_q[k].period,
                 mon_q[k].cyc, MIN_W, 2 * MIN_W, rise_cyc[k+1] + LAT);
      end
    end
  endtask

  task automatic test_glitch();
    int eh[$];
    int ep[$];
    do_reset(1'b0);
    set_level(1'b0, 10);
    hq = '{30, 2, 30};
    lq = '{20, 48, 70};
`ifdef PWM_CAPTURE_FILTER_EN
    eh = '{30, 30};
    ep = '{100, 100};
`else
    eh = '{30, 2, 30};
    ep = '{50, 50, 100};
`endif
    play();
    n_cmp++;
    if (mon_q.size() != eh.size()) begin n_fail++; $display("FAIL glitch_count: %0d samples, required %0d", mon_q.size(), eh.size()); end
    for (int k = 0; k < mon_q.size() && k < eh.size(); k++) begin
      n_cmp++;
      if (mon_q[k].pulse != eh[k] || mon_q[k].period != ep[k]) begin
        n_fail++;
        $display("FAIL glitch_sample%0d: %0d/%0d, required %0d/%0d", k, mon_q[k].pulse, mon_q[k].period, eh[k], ep[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      set_level(1'b0, $urandom_range(10, 3));
      hq.delete();
      lq.delete();
      repeat ($urandom_range(8, 3)) begin
        hq.push_back($urandom_range(45, MIN_W));
        lq.push_back($urandom_range(45, MIN_W));
      end
      play();
      n_cmp++;
      if (mon_q.size() != hq.size()) begin n_fail++; $display("FAIL rand%0d_count: %0d samples, required %0d", r, mon_q.size(), hq.size()); end
      for (int k = 0; k < mon_q.size() && k < hq.size(); k++) begin
        n_cmp++;
        if (mon_q[k].pulse != hq[k] || mon_q[k].period != hq[k] + lq[k] || mon_q[k].cyc != rise_cyc[k+1] + LAT) begin
          n_fail++;
          $display("FAIL rand%0d_sample%0d: %0d/%0d cyc=%0d, required %0d/%0d cyc=%0d", r, k, mon_q[k].pulse,
                   mon_q[k].period, mon_q[k].cyc, hq[k], hq[k] + lq[k], rise_cyc[k+1] + LAT);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_high_at_reset();
    test_timeout_low();
    test_exact_period();
    test_reset_mid();
    test_min_period();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
